// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: valid/ready word input, one-word holding buffer,
// per-word MSB/LSB-first bit order, gapless back-to-back streaming on dout.
module bit_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic             din_rdy,
  input  logic             sel,
  output logic             dout,
  output logic             dout_vld,
  output logic             sof,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] buf_word_q, buf_word_d;
  logic             buf_sel_q, buf_sel_d;
  logic             buf_full_q, buf_full_d;
  logic [WIDTH-1:0] sh_word_q, sh_word_d;
  logic             sh_sel_q, sh_sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             sof_q, sof_d;
  logic             busy_q, busy_d;

  logic             accept_c;
  logic             load_c;
  logic [CW-1:0]    idx_c;

  assign din_rdy  = !buf_full_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign sof      = sof_q;
  assign busy     = busy_q;

  // Next state; outputs are precomputed from next state so they can be registered.
  always_comb begin
    state_d    = state_q;
    buf_word_d = buf_word_q;
    buf_sel_d  = buf_sel_q;
    buf_full_d = buf_full_q;
    sh_word_d  = sh_word_q;
    sh_sel_d   = sh_sel_q;
    cnt_d      = cnt_q;

    accept_c = din_vld && !buf_full_q;
    load_c   = buf_full_q && ((state_q == IDLE) || (cnt_q == LAST));

    if (load_c) begin
      sh_word_d  = buf_word_q;
      sh_sel_d   = buf_sel_q;
      cnt_d      = '0;
      state_d    = SHIFT;
      buf_full_d = 1'b0;
    end else if (state_q == SHIFT) begin
      if (cnt_q == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Load and accept are exclusive: load needs a full buffer, accept an empty one.
    if (accept_c) begin
      buf_word_d = din;
      buf_sel_d  = sel;
      buf_full_d = 1'b1;
    end

    idx_c      = sh_sel_d ? (LAST - cnt_d) : cnt_d;
    dout_vld_d = (state_d == SHIFT);
    dout_d     = dout_vld_d && sh_word_d[idx_c];
    sof_d      = dout_vld_d && (cnt_d == '0);
    busy_d     = dout_vld_d || buf_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      buf_word_q <= '0;
      buf_sel_q  <= 1'b0;
      buf_full_q <= 1'b0;
      sh_word_q  <= '0;
      sh_sel_q   <= 1'b0;
      cnt_q      <= '0;
      dout_q     <= 1'b0;
      dout_vld_q <= 1'b0;
      sof_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_word_q <= buf_word_d;
      buf_sel_q  <= buf_sel_d;
      buf_full_q <= buf_full_d;
      sh_word_q  <= sh_word_d;
      sh_sel_q   <= sh_sel_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      sof_q      <= sof_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: WIDTH=8 against a bit-queue reference
// model plus directed sequences, and a WIDTH=2 instance for the narrow case.
module tb_bit_serializer;

  logic       clk;
  logic       rst_n;

  logic [7:0] din8;
  logic       vld8, sel8, rdy8, dout8, dv8, sof8, busy8;
  logic [1:0] din2;
  logic       vld2, sel2, rdy2, dout2, dv2, sof2, busy2;

  int checks = 0;
  int errors = 0;

  bit         mq[$];
  int         emitted;
  logic [7:0] fw[$];
  bit         fs[$];
  logic [1:0] fw2[$];
  bit         gaps;

  bit_serializer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .din_vld(vld8), .din_rdy(rdy8),
    .sel(sel8), .dout(dout8), .dout_vld(dv8), .sof(sof8), .busy(busy8)
  );

  bit_serializer #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .din_vld(vld2), .din_rdy(rdy2),
    .sel(sel2), .dout(dout2), .dout_vld(dv2), .sof(sof2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present the next queued word; a presented word stays put until accepted.
  task automatic feed();
    if (!vld8 && fw.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
      din8 = fw.pop_front();
      sel8 = fs.pop_front();
      vld8 = 1'b1;
    end
    if (!vld2 && fw2.size() > 0) begin
      din2 = fw2.pop_front();
      vld2 = 1'b1;
    end
  endtask

  // One clock; the reference model is the ordered stream of bits still owed.
  task automatic cyc();
    bit         acc8, acc2, b;
    logic [7:0] w;
    bit         s;
    int         rem;
    feed();
    acc8 = (vld8 === 1'b1) && (rdy8 === 1'b1);
    acc2 = (vld2 === 1'b1) && (rdy2 === 1'b1);
    w = din8;
    s = sel8;
    @(posedge clk);
    #1;
    if (acc8) begin
      for (int i = 0; i < 8; i++) mq.push_back(s ? w[7-i] : w[i]);
      vld8 = 1'b0;
    end
    if (acc2) vld2 = 1'b0;
    if (dv8 === 1'b1) begin
      chk("dout8_owed", mq.size() > 0, 1'b1);
      if (mq.size() > 0) begin
        b = mq.pop_front();
        chk("dout8_bit", dout8, b);
        chk("sof8", sof8, (emitted % 8) == 0);
        emitted++;
      end
    end else begin
      chk("dout8_idle", dout8, 1'b0);
      chk("sof8_idle", sof8, 1'b0);
    end
    rem = (8 - (emitted % 8)) % 8;
    chk("busy8", busy8, (dv8 === 1'b1) || (mq.size() > 0));
    chk("rdy8", rdy8, !(mq.size() > rem));
  endtask

  task automatic expect8(input string tag, input logic [31:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk({tag, "_vld"}, dv8, 1'b1);
      chk({tag, "_dout"}, dout8, pat[5'(n - 1 - i)]);
      chk({tag, "_sof"}, sof8, (i % 8) == 0);
    end
  endtask

  initial begin
    logic [31:0] pat;
    logic [3:0]  pat2;
    int          guard;

    rst_n = 1'b0;
    din8 = '0; vld8 = 1'b0; sel8 = 1'b0;
    din2 = '0; vld2 = 1'b0; sel2 = 1'b1;
    emitted = 0;
    gaps = 1'b0;
    #1;
    chk("rst_dout", dout8, 1'b0);
    chk("rst_vld", dv8, 1'b0);
    chk("rst_sof", sof8, 1'b0);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_rdy", rdy8, 1'b1);
    chk("rst_vld2", dv2, 1'b0);
    chk("rst_rdy2", rdy2, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single word, MSB-first
    fw.push_back(8'hB4); fs.push_back(1'b1);
    cyc();
    chk("b4m_latency", dv8, 1'b0);
    chk("b4m_busy", busy8, 1'b1);
    pat = 32'b10110100;
    expect8("b4m", pat, 8);
    cyc();
    chk("b4m_end_vld", dv8, 1'b0);
    chk("b4m_end_busy", busy8, 1'b0);

    // Same word, LSB-first
    fw.push_back(8'hB4); fs.push_back(1'b0);
    cyc();
    chk("b4l_latency", dv8, 1'b0);
    pat = 32'b00101101;
    expect8("b4l", pat, 8);
    cyc();
    chk("b4l_end_vld", dv8, 1'b0);

    // Back-to-back, mixed order, no gap
    fw.push_back(8'hA5); fs.push_back(1'b1);
    fw.push_back(8'h3C); fs.push_back(1'b0);
    cyc();
    chk("b2b_latency", dv8, 1'b0);
    pat = 32'b1010010100111100;
    expect8("b2b", pat, 16);
    cyc();
    chk("b2b_end_vld", dv8, 1'b0);
    chk("b2b_end_busy", busy8, 1'b0);

    // Backpressure: three words offered continuously, 24 contiguous bits
    for (int i = 0; i < 3; i++) begin
      fw.push_back(8'($urandom)); fs.push_back(1'($urandom));
    end
    cyc();
    for (int i = 0; i < 24; i++) begin
      cyc();
      chk("bp_contig", dv8, 1'b1);
    end
    cyc();
    chk("bp_end_vld", dv8, 1'b0);
    chk("bp_drained", (mq.size() == 0) && (fw.size() == 0) && !vld8, 1'b1);

    // Reset at bit 3 of 8'hFF with a second word buffered
    fw.push_back(8'hFF); fs.push_back(1'b1);
    fw.push_back(8'($urandom)); fs.push_back(1'($urandom));
    repeat (5) cyc();
    chk("mid_vld", dv8, 1'b1);
    chk("mid_bufd", rdy8, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", dout8, 1'b0);
    chk("mid_rst_vld", dv8, 1'b0);
    chk("mid_rst_sof", sof8, 1'b0);
    chk("mid_rst_busy", busy8, 1'b0);
    chk("mid_rst_rdy", rdy8, 1'b1);
    mq.delete();
    emitted = 0;
    vld8 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fw.push_back(8'h81); fs.push_back(1'b1);
    cyc();
    chk("post_rst_latency", dv8, 1'b0);
    pat = 32'b10000001;
    expect8("post_rst", pat, 8);
    cyc();
    chk("post_rst_end", dv8, 1'b0);

    // WIDTH=2 back-to-back
    fw2.push_back(2'b10);
    fw2.push_back(2'b01);
    cyc();
    chk("w2_latency", dv2, 1'b0);
    pat2 = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("w2_vld", dv2, 1'b1);
      chk("w2_dout", dout2, pat2[2'(3 - i)]);
      chk("w2_sof", sof2, (i % 2) == 0);
    end
    cyc();
    chk("w2_end_vld", dv2, 1'b0);
    chk("w2_end_busy", busy2, 1'b0);

    // Random words with random idle gaps on the input side
    gaps = 1'b1;
    for (int i = 0; i < 40; i++) begin
      fw.push_back(8'($urandom)); fs.push_back(1'($urandom));
    end
    guard = 0;
    while ((fw.size() > 0 || vld8 || mq.size() > 0 || dv8 === 1'b1) && guard < 3000) begin
      cyc();
      guard++;
    end
    chk("rand_no_timeout", guard < 3000, 1'b1);
    chk("rand_drained", mq.size() == 0, 1'b1);
    chk("rand_idle_busy", busy8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the model1 serial-input stage. Accepts WIDTH-bit words over a valid/ready handshake. Emits them one bit per clock on `dout`, MSB-first or LSB-first per word. A one-word holding buffer lets back-to-back words stream with no idle cycle between them, so `dout` can drive model1's serial `in` directly.

## Interface
- `WIDTH`, default 8: word width in bits; legal values ≥ 2.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `din` input WIDTH: parallel word, valid when `din_vld`=1.
- `din_vld` input 1: upstream offers `din`/`sel`.
- `din_rdy` output 1: block can accept a word this cycle.
- `sel` input 1: bit order for the offered word (1 = MSB-first, 0 = LSB-first); sampled with the word.
- `dout` output 1: serial data bit; 0 whenever `dout_vld`=0.
- `dout_vld` output 1: `dout` carries a valid bit this cycle.
- `sof` output 1: first bit of a word is on `dout` this cycle.
- `busy` output 1: a word is in the shifter or the buffer.

## Operation
- Storage:
  - Holding buffer: word, sel and full flag.
  - Shifter: word, sel and bit counter `cnt` of width clog2(WIDTH).
- Accept:
  - `din_rdy` = !buf_full (combinational from state).
  - Transfer occurs at a rising edge with `din_vld && din_rdy`; `din` and `sel` are captured into the buffer and buf_full is set.
  - Upstream holds `din`, `sel` and `din_vld` stable while `din_rdy`=0.
- Shifter states:
  - IDLE: `dout_vld`=0.
  - SHIFT: `dout_vld`=1; the bit shown is bit index `cnt` of the word in chosen order.
- Load condition, evaluated at each edge: buf_full && (IDLE || cnt==WIDTH-1). On load:
  - Shifter takes the buffer word and sel, `cnt`←0, state←SHIFT, buf_full cleared.
  - If `din_vld` is also high that same edge, no capture happens, because `din_rdy` was 0.
- SHIFT, cnt<WIDTH-1: `cnt`←`cnt`+1 each edge.
- SHIFT, cnt==WIDTH-1, buffer empty: state←IDLE.
- Bit order:
  - sel=1: bit i shown = word[WIDTH-1-i].
  - sel=0: bit i shown = word[i].
  - sel of one word never affects another word.
- `sof` = `dout_vld` && cnt==0.
- `busy` = `dout_vld` || buf_full.
- Words are never dropped or reordered except by reset.

## Timing
- Reset (rst_n=0, immediate, no clock needed):
  - `dout`=0, `dout_vld`=0, `sof`=0, `busy`=0, `din_rdy`=1.
  - Buffer empty, shifter IDLE, `cnt`=0.
- Reset mid-word: the in-flight word and the buffered word are discarded and the outputs go to reset values at once. After `rst_n` rises, the first accept can occur at the next edge.
- Latency:
  - Word accepted at edge k into an idle block → bit 0 on `dout` with `sof`=1 after edge k+1.
  - Last bit on `dout` after edge k+WIDTH.
- Throughput:
  - The buffer frees at edge k+1, so the next word can be accepted at edge k+2.
  - With `din_vld` held high, `dout_vld` stays 1 continuously: one word per WIDTH cycles, `sof` every WIDTH cycles.
  - No gap for any WIDTH ≥ 2.
- Boundaries:
  - Buffer full while the shifter is mid-word: `din_rdy`=0 until the load edge.
  - Last bit with buffer empty: `dout_vld` drops to 0 the cycle after the last bit.
  - A word arriving the same edge the last bit ends: it enters the buffer and loads one edge later, leaving a single-cycle gap. This is legal and required.
- All outputs except `din_rdy` are registered.

## Test plan
- Single word, WIDTH=8, din=8'hB4, sel=1:
  - `dout` = 1,0,1,1,0,1,0,0 on 8 consecutive cycles.
  - `sof` only on the first of them.
  - First bit one cycle after the accept edge; `dout_vld`=0 and `busy`=0 afterward.
- Same word, sel=0:
  - `dout` = 0,0,1,0,1,1,0,1.
- Back-to-back 8'hA5 (sel=1) then 8'h3C (sel=0), `din_vld` held high:
  - 16 contiguous `dout_vld` cycles: 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
  - `sof` at cycles 0 and 8.
- Backpressure: offer three words continuously.
  - `din_rdy` low exactly while the buffer is full.
  - Third word held stable until accepted; all 24 bits emerge in order with no loss.
- Reset mid-stream: assert `rst_n`=0 at bit 3 of 8'hFF with a second word buffered.
  - Outputs read 0 immediately, `din_rdy`=1.
  - After release, a new word 8'h81 (sel=1) emits 1,0,0,0,0,0,0,1 with no residue from the discarded words.
- WIDTH=2 back-to-back 2'b10, 2'b01, sel=1:
  - `dout` = 1,0,0,1 contiguous, `sof` on cycles 0 and 2.
